fetch_stage: RTL and testbench

- IF stage of the pipelined core: holds the program counter, drives the instruction ROM address, and captures the returned word into the IF/ID pipeline register.
- Instruction ROM is combinational (address in, 32-bit big-endian-assembled word out, same cycle); it decodes addr[11:0] of a 4 KB window based at 0xBFC00000.
- Consumed by decode. Stall, flush and redirect come from the hazard unit and the EX-stage branch/jump resolution.

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the pipelined core. Holds the fetch PC, drives the
// combinational instruction ROM address and captures the returned word into the
// IF/ID pipeline register.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When defined, a redirect to a
// target with bits [1:0] != 0 raises a sticky misalign_trap and halts fetch.
// When undefined, redirect targets are word-aligned by clearing bits [1:0].
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count,
  output logic        misalign_trap
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] idInstr_q, idInstr_d;
  logic [31:0] idPc_q, idPc_d;
  logic [31:0] idPcPlus4_q, idPcPlus4_d;
  logic        idValid_q, idValid_d;
  logic [31:0] fetchCount_q, fetchCount_d;
  logic        trap_q, trap_d;

  logic        badRedirect;
  logic [31:0] redirectPc;
  logic [31:0] seqPc;

  // Redirect targets are always loaded word-aligned; sequential PC wraps mod 2^32.
  assign redirectPc = redirect_target & 32'hFFFF_FFFC;
  assign seqPc      = fetchPc_q + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign badRedirect = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
  assign badRedirect = 1'b0;
`endif

  // Next-state logic: FSM transitions, next PC and next IF/ID contents.
  always_comb begin
    state_d      = state_q;
    fetchPc_d    = fetchPc_q;
    idInstr_d    = idInstr_q;
    idPc_d       = idPc_q;
    idPcPlus4_d  = idPcPlus4_q;
    idValid_d    = idValid_q;
    fetchCount_d = fetchCount_q;
    trap_d       = trap_q;

    case (state_q)
      BOOT: begin
        state_d   = RUN;
        idInstr_d = NOP_INSTR;
        idValid_d = 1'b0;
      end

      RUN: begin
        if (badRedirect) begin
          state_d   = HALT;
          trap_d    = 1'b1;
          idInstr_d = NOP_INSTR;
          idValid_d = 1'b0;
        end else begin
          if (redirect_valid) begin
            fetchPc_d = redirectPc;
          end else if (!stall_f) begin
            fetchPc_d = seqPc;
          end

          if (flush_d || redirect_valid) begin
            idInstr_d = NOP_INSTR;
            idValid_d = 1'b0;
          end else if (!stall_d) begin
            idInstr_d    = imem_rdata;
            idPc_d       = fetchPc_q;
            idPcPlus4_d  = seqPc;
            idValid_d    = 1'b1;
            fetchCount_d = fetchCount_q + 32'd1;
          end
        end
      end

      HALT: begin
        idInstr_d = NOP_INSTR;
        idValid_d = 1'b0;
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State register with asynchronous reset back to the boot state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      fetchPc_q    <= RESET_VECTOR;
      idInstr_q    <= NOP_INSTR;
      idPc_q       <= 32'd0;
      idPcPlus4_q  <= 32'd0;
      idValid_q    <= 1'b0;
      fetchCount_q <= 32'd0;
      trap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetchPc_q    <= fetchPc_d;
      idInstr_q    <= idInstr_d;
      idPc_q       <= idPc_d;
      idPcPlus4_q  <= idPcPlus4_d;
      idValid_q    <= idValid_d;
      fetchCount_q <= fetchCount_d;
      trap_q       <= trap_d;
    end
  end

  assign imem_addr     = fetchPc_q;
  assign pc_f          = fetchPc_q;
  assign instr_d       = idInstr_q;
  assign pc_d          = idPc_q;
  assign pc_plus4_d    = idPcPlus4_q;
  assign valid_d       = idValid_q;
  assign fetch_count   = fetchCount_q;
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized scoreboard bench for fetch_stage with an
// instruction-stream reference model and a combinational ROM.
module tb_fetch_stage;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        stall_f, stall_d, flush_d, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d, fetch_count;
  logic        valid_d, misalign_trap;

  fetch_stage #(
    .RESET_VECTOR(RESET_VECTOR),
    .NOP_INSTR   (NOP_INSTR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pc_f           (pc_f),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d),
    .fetch_count    (fetch_count),
    .misalign_trap  (misalign_trap)
  );

  // ROM contents: distinct words inside the 4 KB window, a different pattern outside it.
  function automatic logic [31:0] romWord(input logic [31:0] addr);
    if (addr[31:12] != 20'hBFC00) return 32'hDEAD0000 ^ addr;
    if (addr[11:0] == 12'h000) return 32'h00500093;
    return {8'hA5, addr[11:0], 4'h3, addr[9:2]};
  endfunction

  assign imem_rdata = romWord(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcD;
    logic [31:0] pcP4;
    logic [31:0] count;
    logic        valid;
    logic        trap;
  } exp_t;

  exp_t expQ[$];

  int totalChecks = 0;
  int badChecks   = 0;

  // Reference model state: the architectural view of the fetch stream.
  logic [31:0] mPc, mInstr, mPcD, mPcP4, mCount;
  logic        mValid, mTrap;
  bit          mBooting, mHalted;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPc      = RESET_VECTOR;
    mInstr   = NOP_INSTR;
    mPcD     = 32'd0;
    mPcP4    = 32'd0;
    mValid   = 1'b0;
    mCount   = 32'd0;
    mTrap    = 1'b0;
    mBooting = 1'b1;
    mHalted  = 1'b0;
  endtask

  // One clock of the fetch stream: what leaves the PC, what lands in IF/ID.
  task automatic modelStep(input bit sf, input bit sd, input bit fl, input bit rv, input logic [31:0] rt);
    logic [31:0] word;
    logic [31:0] oldPc;
    if (mBooting) begin
      mBooting = 1'b0;
      mInstr   = NOP_INSTR;
      mValid   = 1'b0;
    end else if (mHalted) begin
      mInstr = NOP_INSTR;
      mValid = 1'b0;
    end else if (rv && TRAP_EN && rt[1:0] != 2'b00) begin
      mTrap   = 1'b1;
      mHalted = 1'b1;
      mInstr  = NOP_INSTR;
      mValid  = 1'b0;
    end else begin
      oldPc = mPc;
      word  = romWord(oldPc);
      if (rv) mPc = {rt[31:2], 2'b00};
      else if (!sf) mPc = oldPc + 32'd4;
      if (fl || rv) begin
        mInstr = NOP_INSTR;
        mValid = 1'b0;
      end else if (!sd) begin
        mInstr = word;
        mPcD   = oldPc;
        mPcP4  = oldPc + 32'd4;
        mValid = 1'b1;
        mCount = mCount + 32'd1;
      end
    end
  endtask

  // Drive one cycle of inputs mid-cycle and queue the state expected after the next edge.
  task automatic applyStimulus(input bit sf, input bit sd, input bit fl, input bit rv, input logic [31:0] rt);
    exp_t e;
    @(negedge clk);
    stall_f         = sf;
    stall_d         = sd;
    flush_d         = fl;
    redirect_valid  = rv;
    redirect_target = rt;
    modelStep(sf, sd, fl, rv, rt);
    e.pc    = mPc;
    e.instr = mInstr;
    e.pcD   = mPcD;
    e.pcP4  = mPcP4;
    e.count = mCount;
    e.valid = mValid;
    e.trap  = mTrap;
    expQ.push_back(e);
  endtask

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    case ($urandom_range(0, 2))
      0:       t = {20'hBFC00, 12'($urandom)};
      1:       t = $urandom;
      default: t = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
    endcase
    if (TRAP_EN) t = t & 32'hFFFF_FFFC;
    return t;
  endfunction

  task automatic randomCycle();
    applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, randTarget());
  endtask

  // Monitor: every edge that has a queued expectation is compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("pc_f", pc_f, e.pc);
        checkOutput("imem_addr", imem_addr, e.pc);
        checkOutput("instr_d", instr_d, e.instr);
        checkOutput("pc_d", pc_d, e.pcD);
        checkOutput("pc_plus4_d", pc_plus4_d, e.pcP4);
        checkOutput("valid_d", {31'd0, valid_d}, {31'd0, e.valid});
        checkOutput("fetch_count", fetch_count, e.count);
        checkOutput("misalign_trap", {31'd0, misalign_trap}, {31'd0, e.trap});
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pc_f"}, pc_f, RESET_VECTOR);
    checkOutput({tag, "_instr_d"}, instr_d, NOP_INSTR);
    checkOutput({tag, "_pc_d"}, pc_d, 32'd0);
    checkOutput({tag, "_pc_plus4_d"}, pc_plus4_d, 32'd0);
    checkOutput({tag, "_valid_d"}, {31'd0, valid_d}, 32'd0);
    checkOutput({tag, "_fetch_count"}, fetch_count, 32'd0);
    checkOutput({tag, "_misalign_trap"}, {31'd0, misalign_trap}, 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    stall_f         = 1'b0;
    stall_d         = 1'b0;
    flush_d         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;

    // Free-running fetch from the reset vector, then advance to BFC00010.
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 16 && mPc != 32'hBFC00010; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Full stall for three cycles, then release.
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Redirect wins over stall_f; then wrap-around at the top of the address space.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC00100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // Refetch with stall_f only, and a flush.
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) randomCycle();

    // Asynchronous reset between edges while stalled.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkResetState("async");
    modelReset();
    @(posedge clk);
    #1;
    checkResetState("held");
    rst = 1'b0;

    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 40; i++) randomCycle();

    // Misaligned redirect: trap and halt, or silent alignment, depending on the build.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC00102);
    for (int i = 0; i < 6; i++) randomCycle();

    repeat (3) @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
